// File: rtl/tia_hmove_ctl_pkg.sv
// Shared TIA horizontal-motion definitions: sequencer states, step/phase counts, object indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tia_hmove_ctl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hm_state_e;

  // Movable object indices, in motion-register order
  typedef enum int {
    OBJ_P0  = 0,
    OBJ_P1  = 1,
    OBJ_M0  = 2,
    OBJ_M1  = 3,
    OBJ_BL  = 4,
    OBJ_NUM = 5
  } obj_idx_e;

  localparam int STEPS  = 16;  // steps per motion sequence
  localparam int PHASES = 4;   // clocks per step
  localparam int K_W    = 4;   // step counter width
  localparam int P_W    = 2;   // phase counter width

  localparam logic [K_W-1:0] K_LAST = K_W'(STEPS - 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(PHASES - 1);

  // Number of extra clocks an object receives: signed -8..+7 biased to 0..15
  function automatic logic [3:0] mv_limit(input logic [3:0] hm);
    return hm ^ 4'b1000;
  endfunction

endpackage

// File: rtl/tia_hmove_obj.sv
// Per-object motion register plus extra-clock pulse decode.
// Latency: hm updates on the write edge; mv is combinational from hm and the shared k/p/run.
// Backpressure: none; writes always accepted, clear beats write.
module tia_hmove_obj
  import tia_hmove_ctl_pkg::*;
(
  input  logic           clk,
  input  logic           r_n,
  input  logic           hclr,
  input  logic           wr,
  input  logic [3:0]     d,
  input  logic           run,
  input  logic [K_W-1:0] k,
  input  logic [P_W-1:0] p,
  output logic           mv
);

  logic [3:0] hm;

  // Motion register: reset and clear both zero it, clear has priority over a write
  always_ff @(posedge clk) begin
    if (!r_n) begin
      hm <= 4'd0;
    end else if (hclr) begin
      hm <= 4'd0;
    end else if (wr) begin
      hm <= d;
    end
  end

  // One pulse on the last phase of each step while the step index is below the biased value;
  // uses the live register so a mid-sequence write changes the remaining steps
  always_comb begin
    mv = run && (p == P_LAST) && (k < mv_limit(hm));
  end

endmodule

// File: rtl/tia_hmove_ctl.sv
// HMOVE sequencer: 16 steps x 4 phases, emits extra-clock pulses per object, then a done strobe.
// Latency: busy the cycle after hmove, 64 busy cycles, done on cycle 65.
// Backpressure: none; hmove during RUN/DONE restarts the sequence without a done.
module tia_hmove_ctl
  import tia_hmove_ctl_pkg::*;
#(
  parameter int NOBJ = int'(OBJ_NUM)
) (
  input  logic            clk,
  input  logic            r_n,
  input  logic            hmove,
  input  logic            hclr,
  input  logic [NOBJ-1:0] wr,
  input  logic [3:0]      d,
  output logic [NOBJ-1:0] mv,
  output logic            busy,
  output logic            done
);

  hm_state_e      state, state_nxt;
  logic [K_W-1:0] k, k_nxt;
  logic [P_W-1:0] p, p_nxt;
  logic           run;

  // State and step/phase counters
  always_ff @(posedge clk) begin
    if (!r_n) begin
      state <= ST_IDLE;
      k     <= '0;
      p     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      p     <= p_nxt;
    end
  end

  // Next state; k and p only move in RUN and are parked at zero elsewhere
  always_comb begin
    state_nxt = state;
    k_nxt     = '0;
    p_nxt     = '0;
    case (state)
      ST_IDLE: begin
        if (hmove) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (hmove) begin
          state_nxt = ST_RUN;
        end else if (p == P_LAST) begin
          if (k == K_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            k_nxt = k + 1'b1;
          end
        end else begin
          k_nxt = k;
          p_nxt = p + 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = hmove ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the registered state
  always_comb begin
    run  = (state == ST_RUN);
    busy = run;
    done = (state == ST_DONE);
  end

  for (genvar g = 0; g < NOBJ; g++) begin : g_obj
    tia_hmove_obj u_obj (
      .clk  (clk),
      .r_n  (r_n),
      .hclr (hclr),
      .wr   (wr[g]),
      .d    (d),
      .run  (run),
      .k    (k),
      .p    (p),
      .mv   (mv[g])
    );
  end

endmodule

// File: doc/tia_hmove_ctl.md
TIA_HMOVE_CTL -- requirements
Module: tia_hmove_ctl

Interface
REQ-001 SHALL have parameter NOBJ, default 5, meaning the number of movable objects (P0, P1, M0, M1, BL in index order 0..4).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on the rising edge.
REQ-003 SHALL have port r_n, input, 1, the reset; synchronous and active-low.
REQ-004 SHALL have port hmove, input, 1, the HMOVE strobe; one-clock pulse.
REQ-005 SHALL have port hclr, input, 1, the HMCLR strobe; zeroes all motion registers.
REQ-006 SHALL have port wr, input, NOBJ, one-hot write enables for the motion registers.
REQ-007 SHALL have port d, input, 4, write data: signed two's-complement motion value, -8..+7.
REQ-008 SHALL have port mv, output, NOBJ, extra-clock pulses to each object's position counter.
REQ-009 SHALL have port busy, output, 1, high while the motion sequence runs.
REQ-010 SHALL have port done, output, 1, one-clock pulse when a sequence completes.

Function
REQ-011 SHALL hold one 4-bit motion register hm[i] per object; wr[i]=1 loads d into hm[i] on that edge.
REQ-012 SHALL clear every hm[i] to 0 when hclr=1; hclr wins over any simultaneous wr.
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 SHALL move IDLE->RUN on an edge where hmove=1; busy=1 from the next cycle, with step counter k=0 and phase p=0.
REQ-015 SHALL, in RUN, advance p 0..3 each clock; p wraps at 3 and k increments, so each step spans 4 clocks and there are 16 steps (k=0..15), 64 clocks in total.
REQ-016 SHALL assert mv[i] for exactly one clock, in the p=3 cycle of step k, iff k < (hm[i] XOR 4'b1000) as unsigned.
REQ-017 SHALL therefore produce hm[i]+8 pulses per object per sequence: 0 for hm=-8, 8 for hm=0, 15 for hm=+7.
REQ-018 SHALL evaluate the mv comparison against the current hm[i], so a write during RUN affects the remaining steps immediately.
REQ-019 SHALL go RUN->DONE after the p=3 cycle of k=15; in DONE, done=1 and busy=0 for one clock, then DONE->IDLE.
REQ-020 SHALL restart from k=0, p=0 when hmove=1 occurs in RUN or DONE, and SHALL NOT emit done for the aborted sequence.
REQ-021 SHALL keep mv=0 in IDLE and DONE, and in the p=0..2 cycles of RUN.
REQ-022 SHALL wrap neither k nor p outside RUN; both SHALL be held at 0.

Reset
REQ-023 SHALL, on an edge with r_n=0: set state=IDLE, k=0, p=0, every hm[i]=0, mv=0, busy=0, done=0.
REQ-024 SHALL abort a running sequence on reset with no further mv pulses and no done pulse.
REQ-025 SHALL ignore hmove, hclr and wr on edges where r_n=0.

Structure
REQ-026 SHALL take the state encodings (IDLE/RUN/DONE), the step count (16), the phase count (4) and the object indices from the shared TIA package/include.
REQ-027 SHALL use one sub-module, tia_hmove_obj, instantiated NOBJ times; it holds hm[i] and produces mv[i] from k, p and the RUN flag.
REQ-028 SHALL keep the state machine and the k/p counters in tia_hmove_ctl only.

Verification
REQ-029 SHALL cover: hm[0]=+7 (d=4'b0111), hmove at cycle 0 -> mv[0] pulses at cycles 4,8,...,60 (15 pulses); done=1 at cycle 65 only.
REQ-030 SHALL cover: hm=-8 (1000) on all objects, hmove -> zero mv pulses; busy high cycles 1..64; done at 65.
REQ-031 SHALL cover: hm[4]=0, then hclr and wr[4] with d=+5 on the same edge, then hmove -> hm[4]=0 and exactly 8 pulses on mv[4].
REQ-032 SHALL cover: hmove, then a second hmove at cycle 20 -> counting restarts, busy stays high, a single done pulse at cycle 85, and each object's pulse total = pulses before cycle 20 plus a full hm+8.
REQ-033 SHALL cover: r_n=0 at cycle 30 of a run with hm=+7 -> mv=0 and busy=0 from cycle 31, no done, hm reads back as 0 on the next sequence (8 pulses).
REQ-034 SHALL cover: hm[1]=+7, write hm[1]=-4 at cycle 18 -> mv[1] pulses at cycles 4,8,12,16 only (4 pulses).
